decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/rv_pkg.sv | 29 ++
 rtl/decode_stage_if.sv | 13 +
 rtl/decode_stage_skid_buf.sv | 65 ++++++
 rtl/decode_stage.sv | 126 ++++++++++++
 tb/tb_decode_stage.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode types: ALU control, opcodes, and the decode->ALU packet.
// Imported by decode_stage, skid_buf and decode_stage_if.
package rv_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_ctl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_ctl_t    ctl;
        logic [4:0]  rd;
        logic        illegal;
    } ex_pkt_t;

    function automatic logic funct3_ok(logic [2:0] f3);
        return (f3 != 3'b001) && (f3 != 3'b101);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Valid/ready handshake bundle carrying one decoded packet toward the ALU.
// The producer drives valid/data; the consumer drives ready.
interface decode_stage_if;
    import rv_pkg::*;

    logic    valid;
    logic    ready;
    ex_pkt_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/decode_stage_skid_buf.sv
// skid_buf: 2-entry FIFO with registered in_ready, no ready->ready comb path.
// Payload type is a parameter; synchronous active-low reset empties it.
module skid_buf #(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic [1:0] cnt_q, cnt_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       ready_q, ready_d;
    T           mem_q [2];
    T           mem_d [2];

    logic push, pop, wr_ptr;

    assign push   = in_valid && ready_q;
    assign pop    = (cnt_q != 2'd0) && out_ready;
    assign wr_ptr = rd_ptr_q ^ cnt_q[0];

    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr] = in_data;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            ready_q  <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            mem_q    <= mem_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/decode_stage.sv
// RV32I ALU-subset decode with WB forwarding feeding a 2-entry skid buffer.
// DECODE_ILLEGAL_TRAP_EN: emit illegal instrs flagged on ex_illegal instead of dropping.
module decode_stage
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [2:0]  ex_ctl,
    output logic [4:0]  ex_rd
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic        ex_illegal
`endif
);

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_op, is_imm, legal;
    logic [31:0] op_a, op_b, imm;
    ex_pkt_t     dec_pkt, out_pkt;
    logic        push_valid, push_ready;

    decode_stage_if ex_if ();

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign imm      = {{20{instr[31]}}, instr[31:20]};

    assign is_op  = (opcode == OPC_OP) && (funct7 == 7'd0)
                 && funct3_ok(funct3);
    assign is_imm = (opcode == OPC_OP_IMM) && funct3_ok(funct3);
    assign legal  = is_op || is_imm;

    // x0 reads as zero even if forwarding or the regfile disagree
    always_comb begin
        op_a = rs1_data;
        if (rs1_addr == 5'd0) begin
            op_a = '0;
        end else if (wb_we && (wb_rd == rs1_addr)) begin
            op_a = wb_data;
        end
        op_b = rs2_data;
        if (rs2_addr == 5'd0) begin
            op_b = '0;
        end else if (wb_we && (wb_rd == rs2_addr)) begin
            op_b = wb_data;
        end
    end

    always_comb begin
        dec_pkt = '0;
        unique case (1'b1)
            is_op: begin
                dec_pkt.a   = op_a;
                dec_pkt.b   = op_b;
                dec_pkt.ctl = alu_ctl_t'(funct3);
                dec_pkt.rd  = instr[11:7];
            end
            is_imm: begin
                dec_pkt.a   = op_a;
                dec_pkt.b   = imm;
                dec_pkt.ctl = alu_ctl_t'(funct3);
                dec_pkt.rd  = instr[11:7];
            end
            default: begin
                dec_pkt.illegal = 1'b1;
            end
        endcase
    end

    // illegal instrs still handshake upstream; they just never enter the buffer
    assign push_valid  = instr_valid && (legal || TRAP_EN);
    assign instr_ready = push_ready;

    skid_buf #(.T(ex_pkt_t)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_valid),
        .in_ready  (push_ready),
        .in_data   (dec_pkt),
        .out_valid (ex_if.valid),
        .out_ready (ex_if.ready),
        .out_data  (ex_if.data)
    );

    assign ex_if.ready = ex_ready;
    assign out_pkt     = ex_if.valid ? ex_if.data : '0;

    assign ex_valid = ex_if.valid;
    assign ex_a     = out_pkt.a;
    assign ex_b     = out_pkt.b;
    assign ex_ctl   = out_pkt.ctl;
    assign ex_rd    = out_pkt.rd;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign ex_illegal = out_pkt.illegal;
`else
    logic unused_illegal;
    assign unused_illegal = out_pkt.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic vs a queue model.
// Honors DECODE_ILLEGAL_TRAP_EN the same way the design does.
module tb_decode_stage;
    import rv_pkg::*;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_a, ex_b;
    logic [2:0]  ex_ctl;
    logic [4:0]  ex_rd;
    logic        ill_w;

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_ctl      (ex_ctl),
        .ex_rd       (ex_rd)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .ex_illegal  (ill_w)
`endif
    );

`ifndef DECODE_ILLEGAL_TRAP_EN
    assign ill_w = 1'b0;
`endif

    decode_stage_if mon ();
    assign mon.valid = ex_valid;
    assign mon.ready = ex_ready;
    assign mon.data  = '{a: ex_a, b: ex_b, ctl: alu_ctl_t'(ex_ctl),
                         rd: ex_rd, illegal: ill_w};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] regs [32];
    ex_pkt_t     q [$];
    bit          m_ready;
    logic [2:0]  f3s [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

    function automatic logic [31:0] r_type(logic [6:0] f7, logic [4:0] r2,
        logic [4:0] r1, logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
        return {f7, r2, r1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] i_type(logic [11:0] im, logic [4:0] r1,
        logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
        return {im, r1, f3, rd, opc};
    endfunction

    function automatic bit is_legal(logic [31:0] i);
        bit f_ok;
        f_ok = i[14:12] inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        return f_ok && ((i[6:0] == 7'h33 && i[31:25] == 7'd0)
                        || i[6:0] == 7'h13);
    endfunction

    function automatic logic [31:0] opnd(logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_rd == a) return wb_data;
        return regs[a];
    endfunction

    function automatic ex_pkt_t ref_pkt(logic [31:0] i);
        ex_pkt_t p;
        p = '0;
        if (is_legal(i)) begin
            p.a   = opnd(i[19:15]);
            p.b   = (i[6:0] == 7'h13) ? {{20{i[31]}}, i[31:20]}
                                      : opnd(i[24:20]);
            p.ctl = alu_ctl_t'(i[14:12]);
            p.rd  = i[11:7];
        end else begin
            p.illegal = 1'b1;
        end
        return p;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, logic [31:0] i);
        instr_valid = v;
        instr       = i;
        rs1_data    = regs[i[19:15]];
        rs2_data    = regs[i[24:20]];
    endtask

    // check outputs against the model, advance the model, cross one edge
    task automatic tick();
        ex_pkt_t e, np;
        bit      fire, pop;
        #1;
        e = (q.size() != 0) ? q[0] : '0;
        chk("instr_ready", instr_ready, m_ready);
        chk("ex_valid", mon.valid, q.size() != 0);
        chk("ex_a", mon.data.a, e.a);
        chk("ex_b", mon.data.b, e.b);
        chk("ex_ctl", mon.data.ctl, e.ctl);
        chk("ex_rd", mon.data.rd, e.rd);
        if (TRAP) chk("ex_illegal", mon.data.illegal, e.illegal);
        chk("rs1_addr", rs1_addr, instr[19:15]);
        chk("rs2_addr", rs2_addr, instr[24:20]);
        if (!rst_n) begin
            q.delete();
            m_ready = 1'b0;
        end else begin
            fire = instr_valid && m_ready;
            pop  = (q.size() != 0) && ex_ready;
            np   = ref_pkt(instr);
            if (pop) void'(q.pop_front());
            if (fire && (is_legal(instr) || TRAP)) q.push_back(np);
            m_ready = (q.size() < 2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        regs[0]  = 32'd55;
        rst_n    = 1'b0;
        ex_ready = 1'b0;
        wb_we    = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = 32'd0;
        m_ready  = 1'b0;
        drive(1'b0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", instr_ready, 1'b1);

        // ADDI x5,x1,-1
        regs[1]  = 32'd10;
        ex_ready = 1'b1;
        drive(1'b1, i_type(12'hFFF, 5'd1, 3'd0, 5'd5, 7'h13));
        tick();
        drive(1'b0, 32'd0);
        chk("addi_valid", ex_valid, 1'b1);
        chk("addi_a", ex_a, 32'd10);
        chk("addi_b", ex_b, 32'hFFFF_FFFF);
        chk("addi_ctl", ex_ctl, 3'b000);
        chk("addi_rd", ex_rd, 5'd5);
        tick();

        // XOR x3,x1,x2 with and without forwarding
        regs[2] = 32'd99;
        wb_we   = 1'b1;
        wb_rd   = 5'd2;
        wb_data = 32'd7;
        drive(1'b1, r_type(7'd0, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33));
        tick();
        chk("xor_fwd_b", ex_b, 32'd7);
        wb_rd = 5'd0;
        tick();
        chk("xor_nofwd_b", ex_b, 32'd99);
        wb_we = 1'b0;

        // SLT x4,x0,x2 with garbage on the x0 read port
        drive(1'b1, r_type(7'd0, 5'd2, 5'd0, 3'd2, 5'd4, 7'h33));
        tick();
        drive(1'b0, 32'd0);
        chk("slt_a", ex_a, 32'd0);
        chk("slt_ctl", ex_ctl, 3'b010);
        tick();

        // back-pressure: three back-to-back, buffer fills at two
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, i_type(12'(k + 1), 5'd1, 3'd6, 5'(10 + k), 7'h13));
            if (k < 2) tick();
        end
        chk("full_ready", instr_ready, 1'b0);
        tick();
        tick();
        chk("stall_rd", ex_rd, 5'd10);
        ex_ready = 1'b1;
        tick();
        chk("drain_rd1", ex_rd, 5'd11);
        tick();
        drive(1'b0, 32'd0);
        chk("drain_rd2", ex_rd, 5'd12);
        tick();
        chk("drain_empty", ex_valid, 1'b0);

        // SUB x1,x2,x3 then ADD x1,x2,x3
        drive(1'b1, r_type(7'h20, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33));
        tick();
        drive(1'b1, r_type(7'd0, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33));
        chk("sub_valid", ex_valid, TRAP);
        if (TRAP) chk("sub_ill", ill_w, 1'b1);
        tick();
        drive(1'b0, 32'd0);
        chk("add_valid", ex_valid, 1'b1);
        chk("add_rd", ex_rd, 5'd1);
        tick();

        // reset with two entries held
        ex_ready = 1'b0;
        drive(1'b1, i_type(12'd3, 5'd1, 3'd7, 5'd20, 7'h13));
        tick();
        tick();
        drive(1'b0, 32'd0);
        chk("pre_rst_full", instr_ready, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_ready", instr_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", instr_ready, 1'b1);

        // random traffic
        for (int n = 0; n < 500; n++) begin
            logic [31:0] ins;
            int          sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: ins = r_type(7'd0, 5'($urandom), 5'($urandom),
                                f3s[$urandom_range(0, 5)], 5'($urandom), 7'h33);
                1: ins = i_type(12'($urandom), 5'($urandom),
                                f3s[$urandom_range(0, 5)], 5'($urandom), 7'h13);
                2: ins = r_type(7'h20, 5'($urandom), 5'($urandom),
                                3'($urandom), 5'($urandom), 7'h33);
                3: ins = r_type(7'($urandom), 5'($urandom), 5'($urandom),
                                ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5,
                                5'($urandom),
                                ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13);
                4: ins = i_type(12'($urandom), 5'($urandom), 3'd2,
                                5'($urandom), 7'h03);
                default: ins = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) regs[$urandom_range(0, 31)] = $urandom;
            ex_ready = ($urandom_range(0, 3) != 0);
            wb_we    = ($urandom_range(0, 1) != 0);
            wb_rd    = 5'($urandom);
            wb_data  = $urandom;
            drive($urandom_range(0, 3) != 0, ins);
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
